// File: rtl/count_mod_n_if.sv
// count_mod_n_if: control/status bundle for count_mod_n.
//   master: drives en, cw, clr, ld, ld_val, max_val, sat; observes the status.
//   slave : the counter; drives count, tic, at_max, at_zero.
interface count_mod_n_if #(
    parameter int N = 8
);
    logic         en;       // count enable (advances prescaler)
    logic         cw;       // 1 = up, 0 = down
    logic         clr;      // synchronous clear
    logic         ld;       // synchronous load
    logic [N-1:0] ld_val;   // load value
    logic [N-1:0] max_val;  // upper bound of count range
    logic         sat;      // 0 = wrap, 1 = saturate
    logic [N-1:0] count;    // registered count
    logic         tic;      // registered boundary-step pulse
    logic         at_max;   // count >= max_val
    logic         at_zero;  // count == 0

    modport master (
        output en, cw, clr, ld, ld_val, max_val, sat,
        input  count, tic, at_max, at_zero
    );

    modport slave (
        input  en, cw, clr, ld, ld_val, max_val, sat,
        output count, tic, at_max, at_zero
    );
endinterface

// File: rtl/count_mod_n.sv
// count_mod_n: up/down counter over 0..max_val with wrap or saturate mode,
// synchronous clear/load, an enable prescaler and a terminal-count pulse.
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : count_mod_n_if.slave (controls in, count/tic/at_max/at_zero out)
module count_mod_n #(
    parameter int N        = 8,
    parameter int PRESCALE = 1
) (
    input  logic         clk,
    input  logic         rst,
    count_mod_n_if.slave bus
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    logic [N-1:0]  count_q, count_d;
    logic [PW-1:0] pre_q, pre_d;
    logic          tic_q, tic_d;

    logic step;
    assign step = (pre_q == PRE_LAST);

    always_comb begin
        count_d = count_q;
        pre_d   = pre_q;
        tic_d   = 1'b0;
        if (bus.clr) begin
            count_d = '0;
            pre_d   = '0;
        end else if (bus.ld) begin
            // Loads are clamped into range so count never starts above max_val.
            count_d = (bus.ld_val > bus.max_val) ? bus.max_val : bus.ld_val;
            pre_d   = '0;
        end else if (bus.en) begin
            if (!step) begin
                pre_d = pre_q + PW'(1);
            end else begin
                pre_d = '0;
                if (bus.cw) begin
                    // >= also catches a count left above a lowered max_val.
                    if (count_q >= bus.max_val) begin
                        count_d = bus.sat ? bus.max_val : '0;
                        tic_d   = 1'b1;
                    end else begin
                        count_d = count_q + N'(1);
                    end
                end else begin
                    if (count_q == '0) begin
                        count_d = bus.sat ? '0 : bus.max_val;
                        tic_d   = 1'b1;
                    end else if (count_q > bus.max_val) begin
                        // Out of range after a max_val decrease: pull back in, no pulse.
                        count_d = bus.max_val;
                    end else begin
                        count_d = count_q - N'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
            pre_q   <= '0;
            tic_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            pre_q   <= pre_d;
            tic_q   <= tic_d;
        end
    end

    assign bus.count   = count_q;
    assign bus.tic     = tic_q;
    assign bus.at_max  = (count_q >= bus.max_val);
    assign bus.at_zero = (count_q == '0);
endmodule

// File: tb/tb_count_mod_n.sv
module tb_count_mod_n;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    count_mod_n_if #(.N(N)) bus1 ();
    count_mod_n_if #(.N(N)) bus3 ();

    assign bus3.en      = bus1.en;
    assign bus3.cw      = bus1.cw;
    assign bus3.clr     = bus1.clr;
    assign bus3.ld      = bus1.ld;
    assign bus3.ld_val  = bus1.ld_val;
    assign bus3.max_val = bus1.max_val;
    assign bus3.sat     = bus1.sat;

    count_mod_n #(.N(N), .PRESCALE(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    count_mod_n #(.N(N), .PRESCALE(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

    typedef struct {
        int cnt;
        int pre;
        bit tic;
    } mst_t;

    mst_t m1, m3;
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: one clock edge of the counter, straight from the rules.
    function automatic mst_t mnext(mst_t s, int ps, int m, bit en, bit cw, bit clr,
                                   bit ld, int ldv, bit sat);
        mst_t r;
        r = s;
        r.tic = 0;
        if (clr) begin
            r.cnt = 0; r.pre = 0;
        end else if (ld) begin
            r.cnt = (ldv < m) ? ldv : m; r.pre = 0;
        end else if (en) begin
            if (s.pre + 1 < ps) begin
                r.pre = s.pre + 1;
            end else begin
                r.pre = 0;
                if (cw) begin
                    if (s.cnt < m) r.cnt = s.cnt + 1;
                    else begin r.cnt = sat ? m : 0; r.tic = 1; end
                end else begin
                    if (s.cnt == 0) begin r.cnt = sat ? 0 : m; r.tic = 1; end
                    else if (s.cnt > m) r.cnt = m;
                    else r.cnt = s.cnt - 1;
                end
            end
        end
        return r;
    endfunction

    task automatic check_both();
        chk("p1 count",   int'(bus1.count),   m1.cnt);
        chk("p1 tic",     int'(bus1.tic),     int'(m1.tic));
        chk("p1 at_max",  int'(bus1.at_max),  int'(m1.cnt >= int'(bus1.max_val)));
        chk("p1 at_zero", int'(bus1.at_zero), int'(m1.cnt == 0));
        chk("p3 count",   int'(bus3.count),   m3.cnt);
        chk("p3 tic",     int'(bus3.tic),     int'(m3.tic));
        chk("p3 at_max",  int'(bus3.at_max),  int'(m3.cnt >= int'(bus1.max_val)));
        chk("p3 at_zero", int'(bus3.at_zero), int'(m3.cnt == 0));
    endtask

    // One clock: update models at the edge, compare 1 time unit later,
    // return at the following falling edge ready for new inputs.
    task automatic cyc();
        @(posedge clk);
        if (!rst) begin
            m1 = '{0, 0, 0};
            m3 = '{0, 0, 0};
        end else begin
            m1 = mnext(m1, 1, int'(bus1.max_val), bus1.en, bus1.cw, bus1.clr, bus1.ld,
                       int'(bus1.ld_val), bus1.sat);
            m3 = mnext(m3, 3, int'(bus1.max_val), bus1.en, bus1.cw, bus1.clr, bus1.ld,
                       int'(bus1.ld_val), bus1.sat);
        end
        #1;
        check_both();
        @(negedge clk);
    endtask

    task automatic drive(input bit en, input bit cw, input bit clr, input bit ld,
                         input int ldv, input int mx, input bit sat);
        bus1.en = en; bus1.cw = cw; bus1.clr = clr; bus1.ld = ld;
        bus1.ld_val = N'(ldv); bus1.max_val = N'(mx); bus1.sat = sat;
    endtask

    task automatic async_reset();
        #2 rst = 1'b0;
        #1;
        chk("rst count", int'(bus1.count), 0);
        chk("rst tic", int'(bus1.tic), 0);
        chk("rst at_zero", int'(bus1.at_zero), 1);
        chk("rst at_max", int'(bus1.at_max), int'(bus1.max_val == 0));
        chk("rst p3 count", int'(bus3.count), 0);
        m1 = '{0, 0, 0};
        m3 = '{0, 0, 0};
        cyc();
        rst = 1'b1;
    endtask

    initial begin
        m1 = '{0, 0, 0};
        m3 = '{0, 0, 0};
        drive(0, 1, 0, 0, 0, 9, 0);
        #2;
        chk("init count", int'(bus1.count), 0);
        chk("init at_zero", int'(bus1.at_zero), 1);
        chk("init at_max", int'(bus1.at_max), 0);
        @(negedge clk);
        rst = 1'b1;

        // Count up to 5, then async reset between edges, then recount.
        drive(1, 1, 0, 0, 0, 9, 0);
        for (int i = 0; i < 5; i++) cyc();
        chk("pre-rst count", int'(bus1.count), 5);
        async_reset();
        cyc();
        chk("post-rst 1", int'(bus1.count), 1);
        cyc();
        chk("post-rst 2", int'(bus1.count), 2);

        // Priority and clamp.
        drive(1, 1, 1, 1, 3, 9, 0); cyc();
        chk("clr prio", int'(bus1.count), 0);
        drive(0, 1, 0, 1, 12, 9, 0); cyc();
        chk("ld clamp", int'(bus1.count), 9);
        drive(1, 1, 0, 1, 4, 9, 0); cyc();
        chk("ld over en", int'(bus1.count), 4);

        // Lowered max_val from count 8.
        drive(0, 1, 0, 1, 8, 9, 0); cyc();
        drive(1, 1, 0, 0, 0, 5, 0); cyc();
        chk("low max wrap", int'(bus1.count), 0);
        chk("low max wrap tic", int'(bus1.tic), 1);
        drive(0, 1, 0, 1, 8, 9, 0); cyc();
        drive(1, 1, 0, 0, 0, 5, 1); cyc();
        chk("low max sat", int'(bus1.count), 5);
        chk("low max sat tic", int'(bus1.tic), 1);
        drive(0, 1, 0, 1, 8, 9, 0); cyc();
        drive(1, 0, 0, 0, 0, 5, 0); cyc();
        chk("low max down", int'(bus1.count), 5);
        chk("low max down tic", int'(bus1.tic), 0);

        // Wrap up through 9 -> 0.
        drive(0, 1, 1, 0, 0, 9, 0); cyc();
        drive(1, 1, 0, 0, 0, 9, 0);
        for (int i = 0; i < 10; i++) cyc();
        chk("wrap 0", int'(bus1.count), 0);
        chk("wrap tic", int'(bus1.tic), 1);
        drive(1, 0, 0, 0, 0, 9, 0); cyc();
        chk("wrap down 9", int'(bus1.count), 9);
        chk("wrap down tic", int'(bus1.tic), 1);

        // Randomized run against the model.
        for (int i = 0; i < 3000; i++) begin
            bus1.clr = ($urandom_range(0, 29) == 0);
            bus1.ld  = ($urandom_range(0, 24) == 0);
            bus1.en  = ($urandom_range(0, 3) != 0);
            bus1.ld_val = N'($urandom_range(0, 15));
            if ($urandom_range(0, 15) == 0) bus1.cw = ~bus1.cw;
            if ($urandom_range(0, 39) == 0) bus1.sat = ~bus1.sat;
            if ($urandom_range(0, 29) == 0) begin
                case ($urandom_range(0, 3))
                    0: bus1.max_val = '0;
                    1: bus1.max_val = '1;
                    2: bus1.max_val = N'(9);
                    default: bus1.max_val = N'($urandom_range(0, 15));
                endcase
            end
            if ($urandom_range(0, 499) == 0) async_reset();
            else cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/count_mod_n.md
# count_mod_n

Parametrised up/down counter with a programmable modulus, wrap or saturate mode, synchronous clear and load, an enable prescaler, and a terminal-count pulse. It replaces the fixed free-running N-bit up/down counter wherever a design needs a bounded range (0..max_val), event division, or a wrap indication. Examples are display multiplexing, timebase generation and position counters.

## Interface

**Parameters**
- N, 8: counter width in bits; N >= 1.
- PRESCALE, 1: number of qualified `en` cycles per count step; PRESCALE >= 1.

**Ports**
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset; release is synchronous to clk (release synchronisation is done by the integrator).
- en  input  1  count enable; each high cycle advances the prescaler.
- cw  input  1  direction: 1 = up, 0 = down; sampled on the step cycle.
- clr  input  1  synchronous clear.
- ld  input  1  synchronous load.
- ld_val  input  N  value to load.
- max_val  input  N  upper bound of the count range; may change at any time.
- sat  input  1  0 = wrap, 1 = saturate at bounds.
- count  output  N  registered count value.
- tic  output  1  registered one-cycle pulse on a boundary step.
- at_max  output  1  combinational: count >= max_val.
- at_zero  output  1  combinational: count == 0.

## Operation

**State**
- count register, N bits.
- prescaler register pre, width max(1, clog2(PRESCALE)), range 0..PRESCALE-1.
- tic register.

**Per-edge priority (highest first)**
- clr: count <= 0, pre <= 0, tic <= 0.
- ld: count <= min(ld_val, max_val), pre <= 0, tic <= 0. `en` is ignored this cycle.
- en:
  - step = (pre == PRESCALE-1).
  - If step: pre <= 0 and count updates per the step rules below.
  - Otherwise: pre <= pre+1 and count holds.
  - tic <= (step and boundary).
- Otherwise: count, pre hold; tic <= 0.

**Step rules (all unsigned, N-bit)**
- Up, count < max_val: count+1.
- Up, count >= max_val (boundary): wrap gives 0; sat gives max_val.
- Down, count == 0 (boundary): wrap gives max_val; sat gives 0.
- Down, count > max_val (out of range after a max_val decrease): count <= max_val. Not a boundary; tic = 0.
- Down, otherwise: count-1.

**Other rules**
- max_val = 0: count is pinned at 0. Every step is a boundary step and pulses tic.
- max_val = 2^N-1 with sat = 0: the counter behaves as a plain N-bit wrap-around counter.
- `en` low pauses the prescaler; pre keeps its value and is not reset.
- Changing `cw` or `sat` between steps has no effect until the next step cycle.

## Timing

**Reset**
- When rst is low: count = 0, pre = 0, tic = 0 immediately, with no clock edge needed.
- at_zero = 1 and at_max = (max_val == 0) while in reset.
- Reset asserted mid-operation overrides everything. After release, counting restarts from 0 with a fresh prescaler.

**Latency**
- A step, clr or ld sampled at edge k is visible on count after edge k.
- tic is high for exactly the cycle following edge k, i.e. the cycle in which count shows the wrapped or saturated value.
- With `en` held high, a step occurs every PRESCALE cycles. The first step after reset, clr or ld occurs on the PRESCALE-th `en` cycle.
- Consecutive boundary steps produce back-to-back tic pulses. Examples: max_val = 0, or sat mode with PRESCALE = 1, pulse tic every cycle.
- at_max and at_zero follow count and max_val combinationally, with no extra register stage.

## Test plan

1. **Async reset.** Count to 5, then drop rst between clock edges. Required: count = 0 and tic = 0 before the next edge. Release rst with en = 1, PRESCALE = 1: count goes 1, 2, ...
2. **Wrap up/down.** N = 4, max_val = 9, sat = 0, en = 1, cw = 1. Required: count 0..9 then 0, with tic high only in the cycle count = 0 after 9. Switch to cw = 0 at count = 0. Required: next value 9 with tic, then 8, 7, ...
3. **Saturate.** max_val = 9, sat = 1, up from 8. Required: count 9, 9, 9 with tic high on every step at 9. Down from 0: count stays 0 with tic each step. at_max = 1 at 9; at_zero = 1 at 0.
4. **Priority and clamp.**
   - clr = ld = en = 1, ld_val = 3. Required: count = 0.
   - ld = 1, ld_val = 12, max_val = 9. Required: count = 9.
   - ld = 1, ld_val = 4 with en = 1. Required: count = 4, no step.
5. **Prescaler.** PRESCALE = 3, en = 1 constant. Required: count increments every 3rd cycle. Drop en for 2 cycles after the first en cycle of a group. Required: the step is delayed by exactly 2 cycles. Apply ld mid-group. Required: the next step occurs 3 en cycles later.
6. **max_val lowered.** count = 8, set max_val = 5.
   - Up step, sat = 0. Required: count = 0, tic = 1.
   - Up step, sat = 1. Required: count = 5, tic = 1.
   - Down step. Required: count = 5, tic = 0.
